// File: rtl/acc_pkg.sv
// Shared types for the accumulator unit: op encodings, condition-flag bundle
// and the LIFO occupancy-width helper.
package acc_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_CLR  = 3'b010,
    OP_INC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  localparam int DEFAULT_STACK_DEPTH = 4;

  // Occupancy must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_OCC_W = occ_width(DEFAULT_STACK_DEPTH);

endpackage

// File: rtl/acc_lifo.sv
// Save/restore stack for the accumulator: register array plus occupancy
// counter; overflow and underflow attempts are reported, never applied.
module acc_lifo
  import acc_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             err_push,
  output logic             err_pop
);

  localparam int OCC_W = occ_width(STACK_DEPTH);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [WIDTH-1:0] mem [STACK_DEPTH];
  logic [OCC_W-1:0] occ;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full     = (occ == OCC_W'(STACK_DEPTH));
  assign empty    = (occ == '0);
  assign err_push = push & full;
  assign err_pop  = pop & empty;
  assign wr_idx   = IDX_W'(occ);
  assign rd_idx   = IDX_W'(occ - OCC_W'(1));
  assign dout     = mem[rd_idx];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else if (push && !full) begin
      occ <= occ + OCC_W'(1);
    end else if (pop && !empty) begin
      occ <= occ - OCC_W'(1);
    end
  end

  // NOTE: the array is deliberately not reset; entries above the occupancy
  // are never read, so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/acc_unit.sv
// Accumulator: AC register, local-op decode, Z/N/C/V flags and a LIFO for
// save/restore of AC without bus traffic.
module acc_unit
  import acc_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ac_in,
  input  logic             c_in,
  input  logic             v_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] bus_out,
  output logic             zflag,
  output logic             nflag,
  output logic             cflag,
  output logic             vflag,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  op_t              op_e;
  logic [WIDTH-1:0] ac;
  logic [WIDTH-1:0] ac_nxt;
  flags_t           fl;
  logic             c_nxt;
  logic             v_nxt;
  logic             ac_wr;
  logic             err;
  logic [WIDTH-1:0] lifo_dout;
  logic             lifo_err_push;
  logic             lifo_err_pop;

  assign op_e = op_t'(op);

  acc_lifo #(
    .WIDTH      (WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .push    (op_e == OP_PUSH),
    .pop     (op_e == OP_POP),
    .din     (ac),
    .dout    (lifo_dout),
    .full    (stack_full),
    .empty   (stack_empty),
    .err_push(lifo_err_push),
    .err_pop (lifo_err_pop)
  );

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    ac_nxt = ac;
    c_nxt  = fl.c;
    v_nxt  = fl.v;
    ac_wr  = 1'b0;
    case (op_e)
      OP_LOAD: begin
        ac_nxt = ac_in;
        c_nxt  = c_in;
        v_nxt  = v_in;
        ac_wr  = 1'b1;
      end
      OP_CLR: begin
        ac_nxt = '0;
        c_nxt  = 1'b0;
        v_nxt  = 1'b0;
        ac_wr  = 1'b1;
      end
      OP_INC: begin
        ac_nxt = ac + WIDTH'(1);
        c_nxt  = &ac;
        v_nxt  = (ac == MAX_POS);
        ac_wr  = 1'b1;
      end
      OP_SHL: begin
        ac_nxt = {ac[WIDTH-2:0], 1'b0};
        c_nxt  = ac[WIDTH-1];
        v_nxt  = ac[WIDTH-1] ^ ac[WIDTH-2];
        ac_wr  = 1'b1;
      end
      OP_SHR: begin
        ac_nxt = {ac[WIDTH-1], ac[WIDTH-1:1]};
        c_nxt  = ac[0];
        v_nxt  = 1'b0;
        ac_wr  = 1'b1;
      end
      OP_POP: begin
        if (!stack_empty) begin
          ac_nxt = lifo_dout;
          c_nxt  = 1'b0;
          v_nxt  = 1'b0;
          ac_wr  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ac  <= '0;
      fl  <= '0;
      err <= 1'b0;
    end else begin
      if (ac_wr) begin
        ac <= ac_nxt;
        fl <= '{z: (ac_nxt == '0), n: ac_nxt[WIDTH-1], c: c_nxt, v: v_nxt};
      end
      // A new error outranks a simultaneous clear request.
      if (lifo_err_push || lifo_err_pop) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  assign alu_out   = ac;
  assign bus_out   = ac;
  assign zflag     = fl.z;
  assign nflag     = fl.n;
  assign cflag     = fl.c;
  assign vflag     = fl.v;
  assign stack_err = err;

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit: an arithmetic model with a queue-based stack
// is compared every cycle, plus literal expectations from worked examples.
module tb_acc_unit;

  localparam int W     = 12;
  localparam int DEPTH = 4;
  localparam int unsigned MOD  = 1 << W;
  localparam int unsigned HALF = 1 << (W - 1);

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, CLR = 3'd2, INC = 3'd3,
                         SHL = 3'd4, SHR = 3'd5, PUSH = 3'd6, POP = 3'd7;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [2:0]   op = NOP;
  logic [W-1:0] ac_in = '0;
  logic         c_in = 1'b0, v_in = 1'b0, err_clr = 1'b0;
  logic [W-1:0] alu_out, bus_out;
  logic         zflag, nflag, cflag, vflag, stack_full, stack_empty, stack_err;

  int checks = 0;
  int errors = 0;

  acc_unit #(.WIDTH(W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .op(op), .ac_in(ac_in), .c_in(c_in),
    .v_in(v_in), .err_clr(err_clr), .alu_out(alu_out), .bus_out(bus_out),
    .zflag(zflag), .nflag(nflag), .cflag(cflag), .vflag(vflag),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: AC as a plain integer, stack as a queue.
  int unsigned m_ac, old;
  bit          m_z, m_n, m_c, m_v, m_err, wrote, new_err, model_valid;
  int unsigned stk[$];

  always @(posedge clk) begin
    if (reset) begin
      m_ac = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_err = 0;
      stk.delete();
      model_valid = 1;
    end else if (model_valid) begin
      old = m_ac; wrote = 1; new_err = 0;
      case (op)
        LOAD: begin m_ac = ac_in; m_c = c_in; m_v = v_in; end
        CLR:  begin m_ac = 0; m_c = 0; m_v = 0; end
        INC:  begin m_ac = (old + 1) % MOD; m_c = (old == MOD - 1); m_v = (old == HALF - 1); end
        SHL:  begin
          m_ac = (old * 2) % MOD;
          m_c  = (old >= HALF);
          m_v  = (old >= HALF) != ((old % HALF) >= HALF / 2);
        end
        SHR:  begin m_ac = old / 2 + ((old >= HALF) ? HALF : 0); m_c = old[0]; m_v = 0; end
        PUSH: begin
          wrote = 0;
          if (stk.size() == DEPTH) new_err = 1; else stk.push_back(old);
        end
        POP:  begin
          if (stk.size() == 0) begin new_err = 1; wrote = 0; end
          else begin m_ac = stk.pop_back(); m_c = 0; m_v = 0; end
        end
        default: wrote = 0;
      endcase
      if (wrote) begin m_z = (m_ac == 0); m_n = (m_ac >= HALF); end
      if (new_err) m_err = 1; else if (err_clr) m_err = 0;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("alu_out", 32'(alu_out), m_ac);
      check("bus_out", 32'(bus_out), m_ac);
      check("zflag", 32'(zflag), 32'(m_z));
      check("nflag", 32'(nflag), 32'(m_n));
      check("cflag", 32'(cflag), 32'(m_c));
      check("vflag", 32'(vflag), 32'(m_v));
      check("stack_full", 32'(stack_full), 32'(stk.size() == DEPTH));
      check("stack_empty", 32'(stack_empty), 32'(stk.size() == 0));
      check("stack_err", 32'(stack_err), 32'(m_err));
    end
  end

  // Apply one op for one cycle; returns shortly after the edge that samples it.
  task automatic step(input logic [2:0] o, input logic [W-1:0] d = '0,
                      input logic c = 1'b0, input logic v = 1'b0, input logic ec = 1'b0);
    op = o; ac_in = d; c_in = c; v_in = v; err_clr = ec;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2;
    reset = 1'b1;
    step(NOP);
    step(NOP);
    reset = 1'b0;
    check("rst_alu", 32'(alu_out), 0);
    check("rst_empty", 32'(stack_empty), 1);
    check("rst_full", 32'(stack_full), 0);
    check("rst_err", 32'(stack_err), 0);

    // 1: load zero with carry
    step(LOAD, 12'h000, 1'b1);
    check("t1_alu", 32'(alu_out), 32'h000);
    check("t1_z", 32'(zflag), 1);
    check("t1_c", 32'(cflag), 1);
    check("t1_empty", 32'(stack_empty), 1);

    // 2: increment across signed and unsigned boundaries
    step(LOAD, 12'h7FF);
    step(INC);
    check("t2_alu", 32'(alu_out), 32'h800);
    check("t2_n", 32'(nflag), 1);
    check("t2_v", 32'(vflag), 1);
    check("t2_c", 32'(cflag), 0);
    step(LOAD, 12'hFFF);
    step(INC);
    check("t2b_alu", 32'(alu_out), 32'h000);
    check("t2b_z", 32'(zflag), 1);
    check("t2b_c", 32'(cflag), 1);

    // 3: shifts
    step(LOAD, 12'hC01);
    step(SHL);
    check("t3_shl", 32'(alu_out), 32'h802);
    check("t3_shl_c", 32'(cflag), 1);
    check("t3_shl_v", 32'(vflag), 0);
    step(SHR);
    check("t3_shr", 32'(alu_out), 32'hC01);
    check("t3_shr_c", 32'(cflag), 0);
    check("t3_shr_n", 32'(nflag), 1);

    // 4: fill, overflow, drain
    step(LOAD, 12'h111); step(PUSH);
    step(LOAD, 12'h222); step(PUSH);
    step(LOAD, 12'h333); step(PUSH);
    step(LOAD, 12'h444); step(PUSH);
    check("t4_full", 32'(stack_full), 1);
    step(PUSH);
    check("t4_err", 32'(stack_err), 1);
    check("t4_hold", 32'(alu_out), 32'h444);
    step(POP);  check("t4_pop1", 32'(alu_out), 32'h444);
    step(CLR);  step(POP); check("t4_pop2", 32'(alu_out), 32'h333);
    step(CLR);  step(POP); check("t4_pop3", 32'(alu_out), 32'h222);
    step(CLR);  step(POP); check("t4_pop4", 32'(alu_out), 32'h111);
    check("t4_empty", 32'(stack_empty), 1);

    // 5: underflow, clear priority
    step(LOAD, 12'h9AB, 1'b1, 1'b1);
    step(NOP, '0, 1'b0, 1'b0, 1'b1);
    check("t5_clr0", 32'(stack_err), 0);
    step(POP);
    check("t5_err", 32'(stack_err), 1);
    check("t5_alu", 32'(alu_out), 32'h9AB);
    check("t5_c", 32'(cflag), 1);
    check("t5_v", 32'(vflag), 1);
    step(POP, '0, 1'b0, 1'b0, 1'b1);
    check("t5_errwins", 32'(stack_err), 1);
    step(NOP, '0, 1'b0, 1'b0, 1'b1);
    check("t5_clr", 32'(stack_err), 0);

    // 6: reset discards stacked data
    step(LOAD, 12'h555);
    step(PUSH);
    step(PUSH);
    reset = 1'b1;
    step(PUSH);
    reset = 1'b0;
    check("t6_alu", 32'(alu_out), 0);
    check("t6_empty", 32'(stack_empty), 1);
    check("t6_flags", 32'({zflag, nflag, cflag, vflag}), 0);
    step(POP);
    check("t6_err", 32'(stack_err), 1);
    check("t6_alu2", 32'(alu_out), 0);

    step(NOP);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
